m_arbiter_port: RTL and testbench

- Master-side responder to the central bus arbiter: one instance per master port.
- Turns a local transfer request into the arbiter handshake: drives `id`, `com_state` and `done`, and obeys the arbiter's `cmd` (WAIT / STOP_S / STOP_P / CLEAR).
- Gates the master's bus datapath and tracks burst progress so a pre-empted transfer resumes where it stopped.
- Sits between the master's transaction logic and the arbiter controller.

---
 rtl/m_arbiter_port.sv | 192 +++++++++++++++++++
 tb/tb_m_arbiter_port.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_arbiter_port.sv
// m_arbiter_port: master-side responder to the central bus arbiter.
// Drives id/com_state/done, gates the datapath and tracks burst progress.
module m_arbiter_port #(
  parameter int NO_SLAVES   = 3,
  parameter int S_ID_WIDTH  = $clog2(NO_SLAVES + 1),
  parameter int LEN_WIDTH   = 12,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [S_ID_WIDTH-1:0] req_slave,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  req_ready,
  input  logic [1:0]            cmd,
  output logic [S_ID_WIDTH-1:0] id,
  output logic [1:0]            com_state,
  output logic                  done,
  input  logic                  slave_ready,
  input  logic                  word_done,
  output logic                  bus_en,
  output logic [LEN_WIDTH-1:0]  word_idx,
  output logic                  xfer_done,
  output logic                  xfer_nak,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACKW,
    S_COM,
    S_DRAIN,
    S_SUSP,
    S_FIN,
    S_NAK
  } state_e;

  localparam logic [1:0] CMD_WAIT   = 2'b00;
  localparam logic [1:0] CMD_STOP_S = 2'b01;
  localparam logic [1:0] CMD_STOP_P = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  localparam logic [1:0] CS_END  = 2'b00;
  localparam logic [1:0] CS_NAK  = 2'b01;
  localparam logic [1:0] CS_WACK = 2'b10;
  localparam logic [1:0] CS_COM  = 2'b11;

  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  state_e               state;
  logic [1:0]           cmd_prev;
  logic [LEN_WIDTH-1:0] len_q;
  logic [TW-1:0]        tmo;

  logic grant;
  logic stop_s;
  logic stop_p;
  logic last_word;
  logic req_ok;

  // A grant is the rising edge into CLEAR; a held CLEAR never re-grants.
  assign grant  = (cmd == CMD_CLEAR) && (cmd_prev != CMD_CLEAR);
  assign stop_s = (cmd == CMD_STOP_S);
  assign stop_p = (cmd == CMD_STOP_P);

  assign last_word = word_done && (word_idx == len_q - 1'b1);

  assign req_ok = req_valid
               && (req_slave != '0)
               && (req_len != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_prev  <= CMD_WAIT;
      len_q     <= '0;
      tmo       <= '0;
      id        <= '0;
      com_state <= CS_END;
      done      <= 1'b0;
      bus_en    <= 1'b0;
      req_ready <= 1'b0;
      xfer_done <= 1'b0;
      xfer_nak  <= 1'b0;
      busy      <= 1'b0;
      word_idx  <= '0;
    end else begin
      cmd_prev  <= cmd;
      req_ready <= 1'b0;
      done      <= 1'b0;
      xfer_done <= 1'b0;
      xfer_nak  <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (req_ok) begin
            state     <= S_REQ;
            len_q     <= req_len;
            id        <= req_slave;
            word_idx  <= '0;
            req_ready <= 1'b1;
            com_state <= CS_WACK;
            busy      <= 1'b1;
          end
        end

        S_REQ: begin
          if (grant) begin
            state <= S_ACKW;
            tmo   <= '0;
          end
        end

        S_ACKW: begin
          if (slave_ready) begin
            state     <= S_COM;
            com_state <= CS_COM;
            bus_en    <= 1'b1;
          end else if (tmo == TMO_LAST) begin
            state     <= S_NAK;
            com_state <= CS_NAK;
            xfer_nak  <= 1'b1;
            id        <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        S_COM: begin
          if (word_done) begin
            word_idx <= word_idx + 1'b1;
          end
          if (last_word) begin
            state     <= S_FIN;
            com_state <= CS_END;
            bus_en    <= 1'b0;
            xfer_done <= 1'b1;
            id        <= '0;
            done      <= stop_s | stop_p;
          end else if (stop_s) begin
            // An unfinished word is simply resent after resume.
            state     <= S_SUSP;
            com_state <= CS_WACK;
            bus_en    <= 1'b0;
            done      <= 1'b1;
          end else if (stop_p) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (word_done) begin
            word_idx <= word_idx + 1'b1;
            done     <= 1'b1;
            bus_en   <= 1'b0;
            if (last_word) begin
              state     <= S_FIN;
              com_state <= CS_END;
              xfer_done <= 1'b1;
              id        <= '0;
            end else begin
              state     <= S_SUSP;
              com_state <= CS_WACK;
            end
          end else if (stop_s) begin
            state     <= S_SUSP;
            com_state <= CS_WACK;
            bus_en    <= 1'b0;
            done      <= 1'b1;
          end
        end

        S_SUSP: begin
          state <= S_REQ;
        end

        S_FIN, S_NAK: begin
          state     <= S_IDLE;
          com_state <= CS_END;
          busy      <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_arbiter_port.sv
// tb_m_arbiter_port: scenario tasks with a word-index scoreboard.
// Expected indices are queued at request time and popped per word.
module tb_m_arbiter_port;

  localparam int SW = 2;
  localparam int LW = 12;

  localparam logic [1:0] WAIT   = 2'b00;
  localparam logic [1:0] STOP_S = 2'b01;
  localparam logic [1:0] STOP_P = 2'b10;
  localparam logic [1:0] CLEAR  = 2'b11;

  localparam logic [1:0] CS_END  = 2'b00;
  localparam logic [1:0] CS_NAK  = 2'b01;
  localparam logic [1:0] CS_WACK = 2'b10;
  localparam logic [1:0] CS_COM  = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [SW-1:0] req_slave;
  logic [LW-1:0] req_len;
  logic          req_ready;
  logic [1:0]    cmd;
  logic [SW-1:0] id;
  logic [1:0]    com_state;
  logic          done;
  logic          slave_ready;
  logic          word_done;
  logic          bus_en;
  logic [LW-1:0] word_idx;
  logic          xfer_done;
  logic          xfer_nak;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_done, cnt_xd, cnt_nak, cnt_bus;

  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] exp;

  m_arbiter_port #(
    .NO_SLAVES(3),
    .S_ID_WIDTH(SW),
    .LEN_WIDTH(LW),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_slave(req_slave),
    .req_len(req_len),
    .req_ready(req_ready),
    .cmd(cmd),
    .id(id),
    .com_state(com_state),
    .done(done),
    .slave_ready(slave_ready),
    .word_done(word_done),
    .bus_en(bus_en),
    .word_idx(word_idx),
    .xfer_done(xfer_done),
    .xfer_nak(xfer_nak),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (done) cnt_done++;
    if (xfer_done) cnt_xd++;
    if (xfer_nak) cnt_nak++;
    if (bus_en) cnt_bus++;
  endtask

  task automatic clr_cnt();
    cnt_done = 0;
    cnt_xd = 0;
    cnt_nak = 0;
    cnt_bus = 0;
  endtask

  task automatic request(input logic [SW-1:0] s, input logic [LW-1:0] l);
    req_valid = 1'b1;
    req_slave = s;
    req_len = l;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(LW'(i));
  endtask

  task automatic grant();
    cmd = WAIT;
    step();
    cmd = CLEAR;
    step();
  endtask

  task automatic ack();
    slave_ready = 1'b1;
    step();
    slave_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({id, com_state, done, bus_en, req_ready, xfer_done, xfer_nak, busy, word_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got id=%0d cs=%0d busy=%0b idx=%0d want all zero", id, com_state, busy, word_idx);
    end
    step();
    step();
    rst = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0 || com_state !== CS_END) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%0b cs=%0d want 0/0", busy, com_state);
    end
  endtask

  task automatic test_invalid();
    clr_cnt();
    req_valid = 1'b1;
    req_slave = 2'd0;
    req_len = 12'd4;
    step();
    req_slave = 2'd1;
    req_len = 12'd0;
    step();
    req_valid = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0 || cnt_bus !== 0) begin
      n_fail++;
      $display("FAIL invalid_req: got busy=%0b bus=%0d want 0/0", busy, cnt_bus);
    end
  endtask

  task automatic test_happy();
    clr_cnt();
    req_valid = 1'b1;
    req_slave = 2'd2;
    req_len = 12'd4;
    cmd = WAIT;
    step();
    n_tests++;
    if (req_ready !== 1'b1 || id !== 2'd2 || com_state !== CS_WACK || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL happy_accept: got rdy=%0b id=%0d cs=%0d busy=%0b want 1/2/2/1", req_ready, id, com_state, busy);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(LW'(i));
    word_done = 1'b1;
    step();
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL happy_busy_req: got rdy=%0b want 0", req_ready);
    end
    req_valid = 1'b0;
    step();
    word_done = 1'b0;
    cmd = CLEAR;
    step();
    n_tests++;
    if (com_state !== CS_WACK || bus_en !== 1'b0) begin
      n_fail++;
      $display("FAIL happy_ackw: got cs=%0d bus=%0b want 2/0", com_state, bus_en);
    end
    ack();
    n_tests++;
    if (com_state !== CS_COM || bus_en !== 1'b1 || id !== 2'd2) begin
      n_fail++;
      $display("FAIL happy_com: got cs=%0d bus=%0b id=%0d want 3/1/2", com_state, bus_en, id);
    end
    for (int i = 0; i < 4; i++) begin
      word_done = 1'b1;
      exp = exp_q.pop_front();
      n_tests++;
      if (word_idx !== exp) begin
        n_fail++;
        $display("FAIL happy_idx: got %0d want %0d", word_idx, exp);
      end
      step();
    end
    word_done = 1'b0;
    n_tests++;
    if (com_state !== CS_END || xfer_done !== 1'b1 || id !== 2'd0 || bus_en !== 1'b0) begin
      n_fail++;
      $display("FAIL happy_fin: got cs=%0d xd=%0b id=%0d bus=%0b want 0/1/0/0", com_state, xfer_done, id, bus_en);
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || cnt_done !== 0 || cnt_xd !== 1) begin
      n_fail++;
      $display("FAIL happy_end: got busy=%0b done=%0d xd=%0d want 0/0/1", busy, cnt_done, cnt_xd);
    end
    cmd = WAIT;
  endtask

  task automatic test_nak();
    int bad;
    clr_cnt();
    request(2'd1, 12'd3);
    grant();
    bad = 0;
    for (int k = 1; k < 16; k++) begin
      if (k == 5) cmd = STOP_S;
      if (k == 8) cmd = STOP_P;
      step();
      if (com_state !== CS_WACK || xfer_nak !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL nak_early: got %0d bad cycles want 0", bad);
    end
    step();
    n_tests++;
    if (com_state !== CS_NAK || xfer_nak !== 1'b1 || id !== 2'd0) begin
      n_fail++;
      $display("FAIL nak_pulse: got cs=%0d nak=%0b id=%0d want 1/1/0", com_state, xfer_nak, id);
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || com_state !== CS_END || cnt_bus !== 0 || cnt_nak !== 1) begin
      n_fail++;
      $display("FAIL nak_end: got busy=%0b cs=%0d bus=%0d nak=%0d want 0/0/0/1", busy, com_state, cnt_bus, cnt_nak);
    end
    exp_q.delete();
    cmd = WAIT;
  endtask

  task automatic test_stop_p();
    int bad;
    clr_cnt();
    request(2'd3, 12'd8);
    grant();
    ack();
    for (int i = 0; i < 3; i++) begin
      word_done = 1'b1;
      exp = exp_q.pop_front();
      n_tests++;
      if (word_idx !== exp) begin
        n_fail++;
        $display("FAIL stopp_idx_a: got %0d want %0d", word_idx, exp);
      end
      step();
    end
    word_done = 1'b0;
    cmd = STOP_P;
    step();
    cmd = CLEAR;
    step();
    n_tests++;
    if (bus_en !== 1'b1 || com_state !== CS_COM || cnt_done !== 0) begin
      n_fail++;
      $display("FAIL stopp_drain: got bus=%0b cs=%0d done=%0d want 1/3/0", bus_en, com_state, cnt_done);
    end
    word_done = 1'b1;
    exp = exp_q.pop_front();
    n_tests++;
    if (word_idx !== exp) begin
      n_fail++;
      $display("FAIL stopp_idx_d: got %0d want %0d", word_idx, exp);
    end
    step();
    word_done = 1'b0;
    n_tests++;
    if (done !== 1'b1 || bus_en !== 1'b0 || word_idx !== 12'd4 || id !== 2'd3) begin
      n_fail++;
      $display("FAIL stopp_susp: got done=%0b bus=%0b idx=%0d id=%0d want 1/0/4/3", done, bus_en, word_idx, id);
    end
    slave_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus_en !== 1'b0 || done !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL stopp_held_clear: got %0d bad cycles want 0", bad);
    end
    grant();
    step();
    slave_ready = 1'b0;
    for (int i = 4; i < 8; i++) begin
      word_done = 1'b1;
      exp = exp_q.pop_front();
      n_tests++;
      if (word_idx !== exp || bus_en !== 1'b1) begin
        n_fail++;
        $display("FAIL stopp_idx_b: got %0d bus=%0b want %0d bus=1", word_idx, bus_en, exp);
      end
      step();
    end
    word_done = 1'b0;
    step();
    n_tests++;
    if (cnt_xd !== 1 || cnt_done !== 1 || busy !== 1'b0 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL stopp_end: got xd=%0d done=%0d busy=%0b q=%0d want 1/1/0/0", cnt_xd, cnt_done, busy, exp_q.size());
    end
    cmd = WAIT;
  endtask

  task automatic test_stop_s();
    clr_cnt();
    request(2'd2, 12'd8);
    grant();
    ack();
    for (int i = 0; i < 2; i++) begin
      word_done = 1'b1;
      exp = exp_q.pop_front();
      n_tests++;
      if (word_idx !== exp) begin
        n_fail++;
        $display("FAIL stops_idx_a: got %0d want %0d", word_idx, exp);
      end
      step();
    end
    word_done = 1'b0;
    cmd = STOP_S;
    step();
    n_tests++;
    if (bus_en !== 1'b0 || done !== 1'b1 || word_idx !== 12'd2 || id !== 2'd2 || com_state !== CS_WACK) begin
      n_fail++;
      $display("FAIL stops_susp: got bus=%0b done=%0b idx=%0d id=%0d cs=%0d want 0/1/2/2/2", bus_en, done, word_idx, id, com_state);
    end
    grant();
    ack();
    for (int i = 2; i < 8; i++) begin
      word_done = 1'b1;
      exp = exp_q.pop_front();
      n_tests++;
      if (word_idx !== exp) begin
        n_fail++;
        $display("FAIL stops_idx_b: got %0d want %0d", word_idx, exp);
      end
      step();
    end
    word_done = 1'b0;
    n_tests++;
    if (xfer_done !== 1'b1 || cnt_done !== 1) begin
      n_fail++;
      $display("FAIL stops_fin: got xd=%0b done=%0d want 1/1", xfer_done, cnt_done);
    end
    step();
    cmd = WAIT;
  endtask

  task automatic test_simul();
    clr_cnt();
    request(2'd1, 12'd2);
    grant();
    ack();
    word_done = 1'b1;
    exp = exp_q.pop_front();
    step();
    exp = exp_q.pop_front();
    n_tests++;
    if (word_idx !== exp) begin
      n_fail++;
      $display("FAIL simul_idx: got %0d want %0d", word_idx, exp);
    end
    cmd = STOP_P;
    step();
    word_done = 1'b0;
    cmd = WAIT;
    n_tests++;
    if (done !== 1'b1 || xfer_done !== 1'b1 || com_state !== CS_END || bus_en !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_fin: got done=%0b xd=%0b cs=%0d bus=%0b want 1/1/0/0", done, xfer_done, com_state, bus_en);
    end
    step();
  endtask

  task automatic test_reset_mid();
    clr_cnt();
    request(2'd2, 12'd8);
    grant();
    ack();
    for (int i = 0; i < 5; i++) begin
      word_done = 1'b1;
      exp = exp_q.pop_front();
      step();
    end
    word_done = 1'b0;
    n_tests++;
    if (word_idx !== 12'd5 || bus_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: got idx=%0d bus=%0b want 5/1", word_idx, bus_en);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({id, com_state, done, bus_en, req_ready, xfer_done, xfer_nak, busy, word_idx} !== '0) begin
      n_fail++;
      $display("FAIL rmid_async: got id=%0d cs=%0d bus=%0b busy=%0b idx=%0d want all zero", id, com_state, bus_en, busy, word_idx);
    end
    exp_q.delete();
    cnt_bus = 0;
    step();
    rst = 1'b0;
    step();
    n_tests++;
    if (cnt_done !== 0 || cnt_xd !== 0 || cnt_nak !== 0) begin
      n_fail++;
      $display("FAIL rmid_pulses: got done=%0d xd=%0d nak=%0d want 0/0/0", cnt_done, cnt_xd, cnt_nak);
    end
    request(2'd3, 12'd2);
    n_tests++;
    if (req_ready !== 1'b1 || id !== 2'd3) begin
      n_fail++;
      $display("FAIL rmid_newreq: got rdy=%0b id=%0d want 1/3", req_ready, id);
    end
    grant();
    ack();
    for (int i = 0; i < 2; i++) begin
      word_done = 1'b1;
      exp = exp_q.pop_front();
      n_tests++;
      if (word_idx !== exp) begin
        n_fail++;
        $display("FAIL rmid_idx: got %0d want %0d", word_idx, exp);
      end
      step();
    end
    word_done = 1'b0;
    step();
    n_tests++;
    if (cnt_xd !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_end: got xd=%0d busy=%0b want 1/0", cnt_xd, busy);
    end
    cmd = WAIT;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_slave = '0;
    req_len = '0;
    cmd = WAIT;
    slave_ready = 1'b0;
    word_done = 1'b0;
    clr_cnt();
    test_reset();
    test_invalid();
    test_happy();
    test_nak();
    test_stop_p();
    test_stop_s();
    test_simul();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
